// File: rtl/memory_arbiter_pkg.sv
// Shared types for the external memory port arbiter: register value type,
// arbiter FSM state encoding and the fixed requester indices.
package memory_arbiter_pkg;

    typedef logic [31:0] regval_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } mem_arb_state_t;

    // Requester slots on the shared port
    localparam int REQ_FETCH = 0;
    localparam int REQ_READ  = 1;
    localparam int REQ_WRITE = 2;

endpackage

// File: rtl/memory_arbiter_rr_picker.sv
// Combinational round-robin picker: returns the first set request bit found
// when searching upward from last+1, wrapping NUM_REQ-1 -> 0.
module rr_picker
    import memory_arbiter_pkg::*;
#(
    parameter int NUM_REQ = 3,
    localparam int IW = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IW-1:0]      last,
    output logic [IW-1:0]      grant,
    output logic               any
);

    logic [IW-1:0] cand;

    // First-set search starting just after the previously served index
    always_comb begin
        grant = '0;
        any   = 1'b0;
        cand  = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            cand = IW'((int'(last) + k) % NUM_REQ);
            if (!any && req[cand]) begin
                any   = 1'b1;
                grant = cand;
            end
        end
    end

endmodule

// File: rtl/memory_arbiter.sv
// Round-robin arbiter sharing one external memory port between NUM_REQ
// requesters (0 fetch, 1 read, 2 write). One transaction outstanding at a
// time, with a response watchdog that returns an error after TIMEOUT_CYCLES.
// Optional feature: define MEMORY_ARBITER_LOCK_EN to add req_lock, which lets
// the granted requester keep the port for a read-modify-write sequence.
module memory_arbiter
    import memory_arbiter_pkg::*;
#(
    parameter int NUM_REQ        = 3,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [NUM_REQ-1:0]    req_enable,
    input  logic [NUM_REQ-1:0]    req_write,
    input  logic [NUM_REQ*32-1:0] req_address,
    input  logic [NUM_REQ*32-1:0] req_data,
`ifdef MEMORY_ARBITER_LOCK_EN
    input  logic [NUM_REQ-1:0]    req_lock,
`endif
    output logic [NUM_REQ-1:0]    resp_valid,
    output logic [NUM_REQ-1:0]    resp_error,
    output logic [31:0]           resp_data,
    output logic                  mem_enable,
    output logic                  mem_write,
    output logic [31:0]           mem_address,
    output logic [31:0]           mem_wdata,
    input  logic                  mem_accept,
    input  logic                  mem_valid,
    input  logic [31:0]           mem_rdata
);

    localparam int IW = $clog2(NUM_REQ);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    localparam logic [1:0] S_IDLE  = IDLE;
    localparam logic [1:0] S_ISSUE = ISSUE;
    localparam logic [1:0] S_WAIT  = WAIT;
    localparam logic [1:0] S_DONE  = DONE;

    logic [1:0]    state_reg;
    logic [IW-1:0] rr_last_reg;
    logic [IW-1:0] grant_reg;
    logic          write_reg;
    regval_t       addr_reg;
    regval_t       wdata_reg;
    logic [TW-1:0] timer_reg;
    logic          err_reg;
    regval_t       resp_data_reg;

    regval_t       addr_arr  [NUM_REQ];
    regval_t       wdata_arr [NUM_REQ];

    logic [IW-1:0] pick_grant;
    logic          pick_any;
    logic [IW-1:0] grant_next;
    logic          start_next;
    logic          locked;

    // Unpack the flat per-requester buses
    genvar gi;
    generate
        for (gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
            assign addr_arr[gi]  = req_address[gi*32 +: 32];
            assign wdata_arr[gi] = req_data[gi*32 +: 32];
        end
    endgenerate

    rr_picker #(.NUM_REQ(NUM_REQ)) u_picker (
        .req   (req_enable),
        .last  (rr_last_reg),
        .grant (pick_grant),
        .any   (pick_any)
    );

`ifdef MEMORY_ARBITER_LOCK_EN
    logic lock_reg;
    // A held lock is honoured only while its owner still requests and locks
    assign locked = lock_reg && req_enable[grant_reg] && req_lock[grant_reg];
`else
    assign locked = 1'b0;
`endif

    // Lock (when present) overrides rotation; otherwise take the picker result
    always_comb begin
        grant_next = pick_grant;
        start_next = pick_any;
        if (locked) begin
            grant_next = grant_reg;
            start_next = 1'b1;
        end
    end

    // Arbiter FSM, command latch, watchdog timer and response capture
    always_ff @(posedge clock) begin
        if (reset) begin
            state_reg     <= S_IDLE;
            rr_last_reg   <= IW'(NUM_REQ - 1);
            grant_reg     <= '0;
            write_reg     <= 1'b0;
            addr_reg      <= '0;
            wdata_reg     <= '0;
            timer_reg     <= '0;
            err_reg       <= 1'b0;
            resp_data_reg <= '0;
`ifdef MEMORY_ARBITER_LOCK_EN
            lock_reg      <= 1'b0;
`endif
        end else begin
            case (state_reg)
                S_IDLE: begin
`ifdef MEMORY_ARBITER_LOCK_EN
                    if (!locked) begin
                        lock_reg <= 1'b0;
                    end
`endif
                    if (start_next) begin
                        grant_reg <= grant_next;
                        write_reg <= req_write[grant_next];
                        addr_reg  <= addr_arr[grant_next];
                        wdata_reg <= wdata_arr[grant_next];
                        state_reg <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    if (mem_accept) begin
                        timer_reg <= '0;
                        state_reg <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    // A completion in the same cycle as the timeout wins
                    if (mem_valid) begin
                        resp_data_reg <= write_reg ? '0 : mem_rdata;
                        err_reg       <= 1'b0;
                        state_reg     <= S_DONE;
                    end else if (timer_reg == TW'(TIMEOUT_CYCLES)) begin
                        resp_data_reg <= '0;
                        err_reg       <= 1'b1;
                        state_reg     <= S_DONE;
                    end else begin
                        timer_reg <= timer_reg + TW'(1);
                    end
                end
                S_DONE: begin
`ifdef MEMORY_ARBITER_LOCK_EN
                    // A locked requester keeps its turn: rotation is frozen
                    if (req_lock[grant_reg]) begin
                        lock_reg <= 1'b1;
                    end else begin
                        lock_reg    <= 1'b0;
                        rr_last_reg <= grant_reg;
                    end
`else
                    rr_last_reg <= grant_reg;
`endif
                    state_reg <= S_IDLE;
                end
                default: state_reg <= S_IDLE;
            endcase
        end
    end

    // Memory command outputs come straight from the latch while issuing
    always_comb begin
        mem_enable  = (state_reg == S_ISSUE);
        mem_write   = mem_enable && write_reg;
        mem_address = mem_enable ? addr_reg  : '0;
        mem_wdata   = mem_enable ? wdata_reg : '0;
    end

    // Completion pulse only reaches a requester that is still asking
    generate
        for (gi = 0; gi < NUM_REQ; gi++) begin : g_resp
            assign resp_valid[gi] = (state_reg == S_DONE) && (grant_reg == IW'(gi)) && req_enable[gi];
            assign resp_error[gi] = resp_valid[gi] && err_reg;
        end
    endgenerate

    assign resp_data = resp_data_reg;

endmodule

// File: tb/tb_memory_arbiter.sv
// Directed bench for memory_arbiter: table-driven arbitration vectors plus
// hand-written sequences for timeout, stalled accept, reset and lock.
module tb_memory_arbiter;

    logic        clock = 1'b0;
    logic        reset;
    logic [2:0]  req_enable;
    logic [2:0]  req_write;
    logic [95:0] req_address;
    logic [95:0] req_data;
`ifdef MEMORY_ARBITER_LOCK_EN
    logic [2:0]  req_lock;
`endif
    logic [2:0]  resp_valid;
    logic [2:0]  resp_error;
    logic [31:0] resp_data;
    logic        mem_enable;
    logic        mem_write;
    logic [31:0] mem_address;
    logic [31:0] mem_wdata;
    logic        mem_accept;
    logic        mem_valid;
    logic [31:0] mem_rdata;

    int errors = 0;
    int checks = 0;
    int cmd_count = 0;

    logic [31:0] addr_tab  [3];
    logic [31:0] wdata_tab [3];

    typedef struct {
        logic [2:0]  mask;
        int          g;
        logic [31:0] rdata;
        logic [31:0] exp;
    } vec_t;
    vec_t vecs [10];

    memory_arbiter #(.NUM_REQ(3), .TIMEOUT_CYCLES(4)) dut (
        .clock       (clock),
        .reset       (reset),
        .req_enable  (req_enable),
        .req_write   (req_write),
        .req_address (req_address),
        .req_data    (req_data),
`ifdef MEMORY_ARBITER_LOCK_EN
        .req_lock    (req_lock),
`endif
        .resp_valid  (resp_valid),
        .resp_error  (resp_error),
        .resp_data   (resp_data),
        .mem_enable  (mem_enable),
        .mem_write   (mem_write),
        .mem_address (mem_address),
        .mem_wdata   (mem_wdata),
        .mem_accept  (mem_accept),
        .mem_valid   (mem_valid),
        .mem_rdata   (mem_rdata)
    );

    always #5 clock = ~clock;

    // Count accepted memory commands
    always @(posedge clock) begin
        if (!reset && mem_enable && mem_accept) cmd_count <= cmd_count + 1;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
        $fatal(1, "timeout");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h required 0x%08h", name, act, exp);
        end
    endtask

    // Wait for the command of requester g, check it, accept it; returns at the first WAIT negedge
    task automatic issue_phase(input int g, input logic w, input int exp_wait, input string tag, output bit ok);
        int waits = 0;
        ok = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clock);
            waits++;
            if (mem_enable) begin
                ok = 1;
                break;
            end
        end
        check({tag, " issued"}, 32'(ok), 32'd1);
        if (ok) begin
            if (exp_wait > 0) check({tag, " latency"}, 32'(waits), 32'(exp_wait));
            check({tag, " address"}, mem_address, addr_tab[g]);
            check({tag, " write"}, 32'(mem_write), 32'(w));
            check({tag, " wdata"}, mem_wdata, wdata_tab[g]);
            mem_accept = 1'b1;
            @(negedge clock);
            mem_accept = 1'b0;
            check({tag, " enable drop"}, 32'(mem_enable), 32'd0);
        end
    endtask

    // Full transaction with a one-cycle memory response
    task automatic do_txn(input int g, input logic w, input logic [31:0] rdata, input logic [31:0] exp,
                          input int exp_wait, input string tag);
        bit ok;
        logic [2:0] oh;
        oh = 3'b001 << g;
        issue_phase(g, w, exp_wait, tag, ok);
        if (ok) begin
            mem_valid = 1'b1;
            mem_rdata = rdata;
            @(negedge clock);
            mem_valid = 1'b0;
            mem_rdata = '0;
            check({tag, " resp_valid"}, 32'(resp_valid), 32'(oh));
            check({tag, " resp_error"}, 32'(resp_error), 32'd0);
            check({tag, " resp_data"}, resp_data, exp);
            $display("txn %s: grant=%0d write=%0d resp_valid=%b resp_data=0x%08h", tag, g, w, resp_valid, resp_data);
        end
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, " mem_enable"}, 32'(mem_enable), 32'd0);
        check({tag, " mem_write"}, 32'(mem_write), 32'd0);
        check({tag, " mem_address"}, mem_address, 32'd0);
        check({tag, " mem_wdata"}, mem_wdata, 32'd0);
        check({tag, " resp_valid"}, 32'(resp_valid), 32'd0);
        check({tag, " resp_error"}, 32'(resp_error), 32'd0);
        check({tag, " resp_data"}, resp_data, 32'd0);
    endtask

    initial begin
        bit ok;
        int cmd_before;

        addr_tab[0]  = 32'h0000_0040; addr_tab[1]  = 32'h0000_0100; addr_tab[2]  = 32'h0000_0200;
        wdata_tab[0] = 32'hD000_0000; wdata_tab[1] = 32'hD000_0001; wdata_tab[2] = 32'hD000_0002;
        req_address  = {addr_tab[2], addr_tab[1], addr_tab[0]};
        req_data     = {wdata_tab[2], wdata_tab[1], wdata_tab[0]};
        req_write    = 3'b100;
        req_enable   = '0;
        mem_accept   = 1'b0;
        mem_valid    = 1'b0;
        mem_rdata    = '0;
`ifdef MEMORY_ARBITER_LOCK_EN
        req_lock     = '0;
`endif

        // Rotation starts after rr_last = 2; req2 is a write so its data reads back 0
        vecs[0] = '{3'b111, 0, 32'h1111_1111, 32'h1111_1111};
        vecs[1] = '{3'b111, 1, 32'h2222_2222, 32'h2222_2222};
        vecs[2] = '{3'b111, 2, 32'h3333_3333, 32'h0000_0000};
        vecs[3] = '{3'b111, 0, 32'h4444_4444, 32'h4444_4444};
        vecs[4] = '{3'b111, 1, 32'h5555_5555, 32'h5555_5555};
        vecs[5] = '{3'b111, 2, 32'h6666_6666, 32'h0000_0000};
        vecs[6] = '{3'b010, 1, 32'hDEAD_BEEF, 32'hDEAD_BEEF};
        vecs[7] = '{3'b101, 2, 32'h7777_7777, 32'h0000_0000};
        vecs[8] = '{3'b101, 0, 32'h8888_8888, 32'h8888_8888};
        vecs[9] = '{3'b001, 0, 32'h9999_9999, 32'h9999_9999};

        reset = 1'b1;
        repeat (3) @(negedge clock);
        check_idle_outputs("reset");
        reset = 1'b0;

        // Table-driven arbitration
        for (int i = 0; i < 10; i++) begin
            req_enable = vecs[i].mask;
            do_txn(vecs[i].g, req_write[vecs[i].g], vecs[i].rdata, vecs[i].exp, (i == 0) ? 1 : 2,
                   $sformatf("vec%0d", i));
        end

        // Timeout: rr_last=0, only req0 asks, memory never answers
        req_enable = 3'b001;
        issue_phase(0, 1'b0, 2, "timeout", ok);
        for (int k = 0; k < 4; k++) begin
            check($sformatf("timeout wait%0d no resp", k), 32'(resp_valid), 32'd0);
            @(negedge clock);
        end
        check("timeout wait4 no resp", 32'(resp_valid), 32'd0);
        @(negedge clock);
        check("timeout resp_valid", 32'(resp_valid), 32'b001);
        check("timeout resp_error", 32'(resp_error), 32'b001);
        check("timeout resp_data", resp_data, 32'd0);
        $display("txn timeout: grant=0 resp_valid=%b resp_error=%b resp_data=0x%08h", resp_valid, resp_error, resp_data);

        // mem_valid on the timeout cycle wins: rr_last=0 -> req1
        req_enable = 3'b010;
        issue_phase(1, 1'b0, 2, "race", ok);
        repeat (4) @(negedge clock);
        mem_valid = 1'b1;
        mem_rdata = 32'hCAFE_F00D;
        @(negedge clock);
        mem_valid = 1'b0;
        mem_rdata = '0;
        check("race resp_valid", 32'(resp_valid), 32'b010);
        check("race resp_error", 32'(resp_error), 32'd0);
        check("race resp_data", resp_data, 32'hCAFE_F00D);
        $display("txn race: grant=1 resp_valid=%b resp_data=0x%08h", resp_valid, resp_data);
        req_enable = '0;
        @(negedge clock);
        check("race pulse width", 32'(resp_valid), 32'd0);
        check("race data hold", resp_data, 32'hCAFE_F00D);

        // Accept withheld: rr_last=1, req1 alone -> req1
        cmd_before = cmd_count;
        req_enable = 3'b010;
        ok = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clock);
            if (mem_enable) begin
                ok = 1;
                break;
            end
        end
        check("stall issued", 32'(ok), 32'd1);
        for (int k = 0; k < 5; k++) begin
            check($sformatf("stall%0d enable", k), 32'(mem_enable), 32'd1);
            check($sformatf("stall%0d address", k), mem_address, addr_tab[1]);
            check($sformatf("stall%0d wdata", k), mem_wdata, wdata_tab[1]);
            @(negedge clock);
        end
        mem_accept = 1'b1;
        @(negedge clock);
        mem_accept = 1'b0;
        check("stall enable drop", 32'(mem_enable), 32'd0);
        mem_valid = 1'b1;
        mem_rdata = 32'h0C0C_0C0C;
        @(negedge clock);
        mem_valid = 1'b0;
        check("stall resp_valid", 32'(resp_valid), 32'b010);
        check("stall resp_data", resp_data, 32'h0C0C_0C0C);
        req_enable = '0;
        repeat (3) @(negedge clock);
        check("stall single command", 32'(cmd_count - cmd_before), 32'd1);
        $display("txn stall: grant=1 commands=%0d resp_data=0x%08h", cmd_count - cmd_before, resp_data);

        // Reset during WAIT, then a late mem_valid: rr_last=1, req0 alone -> req0
        req_enable = 3'b001;
        issue_phase(0, 1'b0, 0, "rst", ok);
        reset = 1'b1;
        req_enable = '0;
        @(negedge clock);
        reset = 1'b0;
        check_idle_outputs("rst after");
        mem_valid = 1'b1;
        mem_rdata = 32'h1234_5678;
        @(negedge clock);
        mem_valid = 1'b0;
        check_idle_outputs("rst late valid");
        @(negedge clock);
        check("rst no resp", 32'(resp_valid), 32'd0);
        $display("txn reset: resp_valid=%b resp_data=0x%08h", resp_valid, resp_data);

        // Enable dropped after grant: rr_last=2 after reset, req2 -> suppressed pulse
        req_enable = 3'b100;
        issue_phase(2, 1'b1, 0, "drop", ok);
        req_enable = '0;
        mem_valid = 1'b1;
        @(negedge clock);
        mem_valid = 1'b0;
        check("drop resp suppressed", 32'(resp_valid), 32'd0);
        $display("txn drop: grant=2 resp_valid=%b", resp_valid);
        // rr_last advanced to 2 despite suppression -> req0 before req1
        req_enable = 3'b011;
        do_txn(0, 1'b0, 32'hABCD_0000, 32'hABCD_0000, 2, "after drop");

`ifdef MEMORY_ARBITER_LOCK_EN
        // Lock: rr_last=0, req1 locks; plain rotation would pick req0 second
        req_lock  = 3'b010;
        req_write = 3'b100;
        req_enable = 3'b011;
        do_txn(1, 1'b0, 32'h5EED_0001, 32'h5EED_0001, 2, "lock read");
        req_write = 3'b110;
        do_txn(1, 1'b1, 32'h5EED_0002, 32'h0000_0000, 2, "lock write");
        req_lock  = 3'b000;
        req_write = 3'b100;
        do_txn(0, 1'b0, 32'h5EED_0003, 32'h5EED_0003, 2, "lock release");
        req_enable = '0;
`endif

        repeat (2) @(negedge clock);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
